// File: rtl/nmi_arbiter_pkg.sv
// ============================================================================
// Module  : nmi_arbiter_pkg
// Brief   : Shared state encoding and constants for the NMI arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package nmi_arbiter_pkg;

    typedef enum logic [2:0] {
        NMIARB_IDLE    = 3'd0,
        NMIARB_SYNC    = 3'd1,
        NMIARB_ASSERT  = 3'd2,
        NMIARB_SERVICE = 3'd3,
        NMIARB_HOLDOFF = 3'd4
    } nmiarb_state_t;

    localparam logic [15:0] NMI_VECTOR = 16'h0066;
    localparam int          OWNER_W    = 3;

endpackage

`default_nettype wire

// File: rtl/cpu_bus.sv
// ============================================================================
// Module  : cpu_bus
// Brief   : Z80 bus signals observed by bus-snooping peripherals.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface cpu_bus;

    logic        m1;
    logic        memreq;
    logic        rd;
    logic [15:0] a_reg;

    modport arb (input m1, input memreq, input rd, input a_reg);
    modport cpu (output m1, output memreq, output rd, output a_reg);

endinterface

`default_nettype wire

// File: rtl/nmi_arbiter_rr_pick.sv
// ============================================================================
// Module  : nmi_arbiter_rr_pick
// Brief   : Combinational round-robin pick: first set bit after ptr, wrapping.
// Revision: 1.0
// ============================================================================
`default_nettype none

module nmi_arbiter_rr_pick #(
    parameter int N = 2
) (
    input  logic [N-1:0] pending,
    input  logic [2:0]   ptr,
    output logic         hit,
    output logic [2:0]   idx
);

    logic [2*N-1:0] doubled;
    logic [N-1:0]   rotated;
    logic [3:0]     start;
    logic [3:0]     pos;
    logic [3:0]     sum;

    // Rotate so bit 0 is the requester just after ptr; then a priority scan.
    assign start   = {1'b0, ptr} + 4'd1;
    assign doubled = {pending, pending};
    assign rotated = N'(doubled >> start);

    always_comb begin
        hit = |rotated;
        pos = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                pos = 4'(k);
            end
        end
    end

    assign sum = start + pos;
    assign idx = (sum >= 4'(N)) ? 3'(sum - 4'(N)) : 3'(sum);

endmodule

`default_nettype wire

// File: rtl/nmi_arbiter.sv
// ============================================================================
// Module  : nmi_arbiter
// Brief   : Round-robin sharing of the Z80 NMI line, frame aligned, with
//           M1-at-0x0066 acceptance. NMI_ARB_TIMEOUT_EN adds an ASSERT timeout.
// Revision: 1.0
// ============================================================================
`default_nettype none

module nmi_arbiter
    import nmi_arbiter_pkg::*;
#(
    parameter int          NREQ           = 2,
    parameter logic [27:0] NMI_TIMEOUT    = 28'd2800000,
    parameter int          HOLDOFF_FRAMES = 2
) (
    input  logic            clk28,
    input  logic            rst,
    cpu_bus.arb             bus,
    input  logic            n_int,
    input  logic            n_int_next,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] done,
    output logic            n_nmi,
    output logic [NREQ-1:0] grant,
    output logic [2:0]      owner,
    output logic            busy,
    output logic            timeout
);

    localparam int HO_W = (HOLDOFF_FRAMES < 1) ? 1 : $clog2(HOLDOFF_FRAMES + 1);
    localparam logic [HO_W-1:0] HO_LOAD = HO_W'(HOLDOFF_FRAMES);

    nmiarb_state_t   state;
    nmiarb_state_t   state_next;

    logic [NREQ-1:0] req_d;
    logic [NREQ-1:0] pending;
    logic [NREQ-1:0] new_req;
    logic [NREQ-1:0] owner_oh;
    logic [2:0]      rr_ptr;
    logic [2:0]      cand_idx;
    logic            cand_hit;
    logic            int_edge;
    logic            vector_fetch;
    logic            owner_done;
    logic            expired;
    logic            latch_owner;
    logic            enter_assert;
    logic            accept;
    logic            release_grant;
    logic            abandon;
    logic [HO_W-1:0] holdoff_cnt;
    logic            unused_bus;

    assign unused_bus   = bus.rd;
    assign int_edge     = n_int & ~n_int_next;
    assign vector_fetch = bus.m1 & bus.memreq & (bus.a_reg == NMI_VECTOR);
    assign new_req      = req & ~req_d;
    assign owner_oh     = NREQ'(1) << owner;
    assign owner_done   = |(done & owner_oh);
    assign busy         = (state != NMIARB_IDLE);

    nmi_arbiter_rr_pick #(
        .N       (NREQ)
    ) u_rr_pick (
        .pending (pending),
        .ptr     (rr_ptr),
        .hit     (cand_hit),
        .idx     (cand_idx)
    );

`ifdef NMI_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(NMI_TIMEOUT + 28'd1);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(NMI_TIMEOUT);

    logic [TO_W-1:0] to_cnt;

    assign expired = (to_cnt == TO_LIMIT - 1'b1);

    // Counts cycles spent in ASSERT; saturates rather than wrapping.
    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            to_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= abandon;
            if (enter_assert) begin
                to_cnt <= '0;
            end else if (state == NMIARB_ASSERT && to_cnt != TO_LIMIT) begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^NMI_TIMEOUT;
    assign expired            = 1'b0;
    assign timeout            = 1'b0;
`endif

    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            state <= NMIARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        latch_owner   = 1'b0;
        enter_assert  = 1'b0;
        accept        = 1'b0;
        release_grant = 1'b0;
        abandon       = 1'b0;
        case (state)
            NMIARB_IDLE: begin
                if (cand_hit) begin
                    latch_owner = 1'b1;
                    state_next  = NMIARB_SYNC;
                end
            end
            NMIARB_SYNC: begin
                if (int_edge) begin
                    enter_assert = 1'b1;
                    state_next   = NMIARB_ASSERT;
                end
            end
            NMIARB_ASSERT: begin
                if (vector_fetch) begin
                    accept     = 1'b1;
                    state_next = NMIARB_SERVICE;
                end else if (expired) begin
                    abandon    = 1'b1;
                    state_next = NMIARB_HOLDOFF;
                end
            end
            NMIARB_SERVICE: begin
                if (owner_done) begin
                    release_grant = 1'b1;
                    state_next    = NMIARB_HOLDOFF;
                end
            end
            NMIARB_HOLDOFF: begin
                if (holdoff_cnt == '0) begin
                    state_next = NMIARB_IDLE;
                end
            end
            default: begin
                state_next = NMIARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            req_d       <= '0;
            pending     <= '0;
            owner       <= '0;
            rr_ptr      <= 3'(NREQ - 1);
            n_nmi       <= 1'b1;
            grant       <= '0;
            holdoff_cnt <= '0;
        end else begin
            req_d <= req;
            // A repeat edge on an already-pending requester folds into the same bit.
            pending <= (pending | new_req) & ~(owner_oh & {NREQ{accept | abandon}});

            if (latch_owner) begin
                owner <= cand_idx;
            end

            if (enter_assert) begin
                rr_ptr <= owner;
                n_nmi  <= 1'b0;
            end else if (accept || abandon) begin
                n_nmi  <= 1'b1;
            end

            if (accept) begin
                grant <= owner_oh;
            end else if (release_grant) begin
                grant <= '0;
            end

            if (release_grant || abandon) begin
                holdoff_cnt <= HO_LOAD;
            end else if (state == NMIARB_HOLDOFF && int_edge && holdoff_cnt != '0) begin
                holdoff_cnt <= holdoff_cnt - 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_nmi_arbiter.sv
// ============================================================================
// Module  : tb_nmi_arbiter
// Brief   : Randomized scoreboard bench for nmi_arbiter with a reference model.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_nmi_arbiter;

    localparam int NREQ    = 2;
    localparam int HOLDOFF = 2;
    localparam int TMO     = 100;
    localparam int FRAME   = 40;

    logic            clk28 = 1'b0;
    logic            rst = 1'b1;
    logic            n_int = 1'b1;
    logic            n_int_next = 1'b1;
    logic [NREQ-1:0] req = '0;
    logic [NREQ-1:0] done = '0;
    logic            n_nmi;
    logic [NREQ-1:0] grant;
    logic [2:0]      owner;
    logic            busy;
    logic            timeout;

    cpu_bus bus ();

    always #5 clk28 = ~clk28;

    nmi_arbiter #(
        .NREQ           (NREQ),
        .NMI_TIMEOUT    (28'(TMO)),
        .HOLDOFF_FRAMES (HOLDOFF)
    ) dut (
        .clk28      (clk28),
        .rst        (rst),
        .bus        (bus),
        .n_int      (n_int),
        .n_int_next (n_int_next),
        .req        (req),
        .done       (done),
        .n_nmi      (n_nmi),
        .grant      (grant),
        .owner      (owner),
        .busy       (busy),
        .timeout    (timeout)
    );

    typedef struct {
        bit is_tmo;
        int idx;
    } exp_t;

    exp_t            expq[$];
    int              n_tests = 0;
    int              n_fail  = 0;
    bit              mon_en  = 1'b0;
    int              fcnt    = 0;
    logic [NREQ-1:0] model_pending = '0;
    int              model_ptr     = NREQ - 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference round-robin: first pending index after ptr, modulo NREQ.
    function automatic int rr_next(input logic [NREQ-1:0] p, input int ptr);
        for (int k = 1; k <= NREQ; k++) begin
            int i;
            i = (ptr + k) % NREQ;
            if (((p >> i) & 1) != 0) return i;
        end
        return -1;
    endfunction

    task automatic pulse(input logic [NREQ-1:0] rmask, input logic [NREQ-1:0] dmask);
        req  = rmask;
        done = dmask;
        @(negedge clk28);
        req  = '0;
        done = '0;
        @(negedge clk28);
    endtask

    task automatic fetch(input logic [15:0] addr);
        bus.m1     = 1'b1;
        bus.memreq = 1'b1;
        bus.rd     = 1'b1;
        bus.a_reg  = addr;
        @(negedge clk28);
        bus.m1     = 1'b0;
        bus.memreq = 1'b0;
        bus.rd     = 1'b0;
        bus.a_reg  = 16'h0000;
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while (busy !== 1'b0 && c < 400) begin
            @(negedge clk28);
            c++;
        end
        check("wait_idle", {31'd0, busy}, 0);
    endtask

    task automatic wait_nmi_low();
        int c;
        c = 0;
        while (n_nmi !== 1'b0 && c < 200) begin
            @(negedge clk28);
            c++;
        end
        check("wait_nmi_low", {31'd0, n_nmi}, 0);
    endtask

    task automatic predict_push(input bit is_tmo, output int idx);
        exp_t e;
        idx      = rr_next(model_pending, model_ptr);
        e.is_tmo = is_tmo;
        e.idx    = idx;
        expq.push_back(e);
        model_ptr = idx;
    endtask

    // Frame interrupt: low for 4 clocks out of FRAME; edge once per frame.
    initial begin
        forever begin
            @(negedge clk28);
            fcnt       = (fcnt + 1) % FRAME;
            n_int      = !(fcnt < 4);
            n_int_next = !(((fcnt + 1) % FRAME) < 4);
        end
    end

    // Monitor: checks every DUT output change against the scoreboard.
    initial begin
        exp_t            e;
        logic            edge_now;
        logic            fetch_now;
        logic            p_nmi = 1'b1;
        logic            p_busy = 1'b0;
        logic            p_tmo = 1'b0;
        logic [NREQ-1:0] p_grant = '0;
        int              low_cycles = 0;
        int              edges_since = 0;
        forever begin
            @(posedge clk28);
            #1;
            if (mon_en) begin
                edge_now  = n_int && !n_int_next;
                fetch_now = bus.m1 && bus.memreq && (bus.a_reg == 16'h0066);
                check("grant_onehot", {31'd0, ($countones(grant) <= 1)}, 1);
                if (grant != '0) check("nmi_high_in_service", {31'd0, n_nmi}, 1);
                if (p_grant != '0 && grant != '0) check("grant_stable", 32'(grant), 32'(p_grant));
                if (p_nmi && !n_nmi) begin
                    check("nmi_on_frame_edge", {31'd0, edge_now}, 1);
                    low_cycles = 0;
                end
                if (!n_nmi) low_cycles++;
                if (edge_now) edges_since++;
                if (p_grant == '0 && grant != '0) begin
                    check("grant_expected", {31'd0, expq.size() > 0}, 1);
                    if (expq.size() > 0) begin
                        e = expq.pop_front();
                        check("grant_kind", {31'd0, e.is_tmo}, 0);
                        check("grant_value", 32'(grant), 32'(1 << e.idx));
                        check("grant_owner", 32'(owner), 32'(e.idx));
                        check("grant_on_fetch", {31'd0, fetch_now}, 1);
                    end
                end
                if (p_grant != '0 && grant == '0) begin
                    check("release_by_owner_done", {31'd0, |(done & p_grant)}, 1);
                    edges_since = 0;
                end
                if (timeout) begin
                    check("timeout_single_pulse", {31'd0, p_tmo}, 0);
                    check("timeout_expected", {31'd0, expq.size() > 0}, 1);
                    if (expq.size() > 0) begin
                        e = expq.pop_front();
                        check("timeout_kind", {31'd0, e.is_tmo}, 1);
                        check("timeout_owner", 32'(owner), 32'(e.idx));
                    end
                    check("timeout_low_cycles", 32'(low_cycles), TMO);
                    check("timeout_nmi_released", {31'd0, n_nmi}, 1);
                    check("timeout_no_grant", 32'(grant), 0);
                    edges_since = 0;
                end
                if (p_busy && !busy) check("holdoff_frames", 32'(edges_since), HOLDOFF);
            end
            p_nmi   = n_nmi;
            p_busy  = busy;
            p_grant = grant;
            p_tmo   = timeout;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus: plays requesters and CPU, keeps the reference model in step.
    initial begin
        logic [NREQ-1:0] mask;
        logic [NREQ-1:0] oh;
        logic [NREQ-1:0] fdone;
        int              idx;
        bit              tmo_round;
        bit              forced2;

        bus.m1     = 1'b0;
        bus.memreq = 1'b0;
        bus.rd     = 1'b0;
        bus.a_reg  = 16'h0000;
        forced2    = 1'b0;

        repeat (3) @(negedge clk28);
        check("reset_n_nmi", {31'd0, n_nmi}, 1);
        check("reset_grant", 32'(grant), 0);
        check("reset_owner", 32'(owner), 0);
        check("reset_busy", {31'd0, busy}, 0);
        check("reset_timeout", {31'd0, timeout}, 0);
        rst = 1'b0;
        @(negedge clk28);
        mon_en = 1'b1;

        for (int r = 0; r < 40; r++) begin
            wait_idle();
            tmo_round = 1'b0;
`ifdef NMI_ARB_TIMEOUT_EN
            tmo_round = (r == 25);
`endif
            idx = -1;
            if (model_pending == '0 && (r % 5) == 1) begin
                fetch(16'h0066);
                check("stray_fetch_nmi", {31'd0, n_nmi}, 1);
                check("stray_fetch_grant", 32'(grant), 0);
            end
            if (model_pending != '0) predict_push(tmo_round, idx);

            mask = NREQ'($urandom_range(0, (1 << NREQ) - 1));
            if (model_pending == '0 && r == 0) mask = '1;
            if (model_pending == '0 && model_ptr == 0 && !forced2 && r > 0) begin
                mask    = '1;
                forced2 = 1'b1;
            end
            if (model_pending == '0 && r == 25 && mask == '0) mask = NREQ'(1);
            if (tmo_round && idx >= 0) mask = '0;
            pulse(mask, '0);
            model_pending = model_pending | mask;
            if (idx < 0 && model_pending != '0) predict_push(tmo_round, idx);
            if (idx < 0) continue;
            oh = NREQ'(1) << idx;

            wait_nmi_low();
            if (tmo_round) begin
                int c;
                c = 0;
                while (timeout !== 1'b1 && c < TMO + 100) begin
                    @(negedge clk28);
                    c++;
                end
                check("wait_timeout", {31'd0, timeout}, 1);
                model_pending = model_pending & ~oh;
                continue;
            end

            repeat ($urandom_range(0, 4)) @(negedge clk28);
            if ($urandom_range(0, 1) == 1) begin
                mask = NREQ'($urandom_range(0, (1 << NREQ) - 1));
                pulse(mask, '0);
                model_pending = model_pending | mask;
            end
            if ($urandom_range(0, 1) == 1) fetch(16'h0038);
            fetch(16'h0066);
            model_pending = model_pending & ~oh;

            repeat ($urandom_range(0, 6)) begin
                if ($urandom_range(0, 2) == 0) begin
                    mask  = NREQ'($urandom_range(0, (1 << NREQ) - 1));
                    fdone = NREQ'($urandom_range(0, (1 << NREQ) - 1)) & ~oh;
                    pulse(mask, fdone);
                    model_pending = model_pending | mask;
                end else begin
                    @(negedge clk28);
                end
            end
            mask = ($urandom_range(0, 3) == 0) ? oh : '0;
            pulse(mask, oh);
            model_pending = model_pending | mask;
        end

        // Reset while the NMI is being asserted: everything is dropped.
        wait_idle();
        if (model_pending == '0) pulse(NREQ'(1), '0);
        wait_nmi_low();
        mon_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_n_nmi", {31'd0, n_nmi}, 1);
        check("async_reset_busy", {31'd0, busy}, 0);
        check("async_reset_grant", 32'(grant), 0);
        repeat (2) @(negedge clk28);
        rst = 1'b0;
        model_pending = '0;
        model_ptr     = NREQ - 1;
        @(negedge clk28);
        mon_en = 1'b1;
        begin
            int bad;
            bad = 0;
            repeat (3 * FRAME) begin
                @(negedge clk28);
                if (n_nmi !== 1'b1 || grant !== '0 || busy !== 1'b0) bad++;
            end
            check("post_reset_quiet", 32'(bad), 0);
        end

        check("scoreboard_drained", 32'(expq.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/nmi_arbiter.md
Name: nmi_arbiter

Overview:
- Shares the single Z80 NMI line between several requesters: magic button, divmmc button, and a spare external source.
- Selects one pending requester round-robin and asserts n_nmi aligned to the frame interrupt.
- Confirms acceptance by the M1 fetch at 0x0066, then holds ownership until the owner signals done.
- Sits between the requester blocks and the CPU; owner/grant outputs let the requester blocks map their ROM/RAM.

Parameters:
- NREQ, 2, number of requesters (1..8).
- NMI_TIMEOUT, 28'd2800000, clk28 cycles allowed in ASSERT before abandoning the request (~100 ms).
- HOLDOFF_FRAMES, 2, frame-interrupt edges to wait after release before the next arbitration.

Ports:
- clk28  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- bus  intf  cpu_bus  CPU bus (uses m1, memreq, rd, a_reg)
- n_int  in  1  current frame interrupt (active low)
- n_int_next  in  1  next-cycle frame interrupt value
- req  in  NREQ  NMI request levels, rising edge = new request
- done  in  NREQ  single-cycle release pulse from each requester
- n_nmi  out  1  NMI to CPU, active low
- grant  out  NREQ  one-hot current owner, valid in SERVICE only
- owner  out  3  index of current/last owner
- busy  out  1  state != IDLE
- timeout  out  1  single-cycle pulse when an ASSERT times out

Behaviour:
- Reset values: n_nmi=1, grant=0, owner=0, busy=0, timeout=0, pending=0, rr_ptr=NREQ-1, state=IDLE.
- Frame edge: int_edge = n_int==1 && n_int_next==0, evaluated each clk28.
- Request capture: req_d registered; pending[i] is set on req[i] & ~req_d[i]. A new edge while pending[i]=1 is absorbed, with no double count. pending[i] is cleared only on grant or timeout of i.
- Round-robin: search pending from rr_ptr+1 upward, wrapping modulo NREQ. The first hit is the candidate. rr_ptr updates to the candidate on entry to ASSERT.
- State machine:
  - IDLE: if any pending, latch candidate into owner and go to SYNC.
  - SYNC: wait for int_edge, then go to ASSERT with n_nmi<=0 in the same clock.
  - ASSERT: n_nmi=0.
    - On bus.m1 && bus.memreq && bus.a_reg==16'h0066: n_nmi<=1, grant<=one-hot(owner), clear pending[owner], go to SERVICE.
    - Timeout counter runs here only (see optional feature).
  - SERVICE: hold grant until done[owner]. Then grant<=0, load holdoff counter with HOLDOFF_FRAMES, go to HOLDOFF. done from non-owners is ignored in every state.
  - HOLDOFF: decrement on each int_edge; at zero go to IDLE. With HOLDOFF_FRAMES=0, go to IDLE on the next clock.
- Simultaneous events:
  - New request edges during any state are captured into pending and do not preempt the current owner.
  - done[owner] in the same cycle as req[owner] edge: release proceeds, and the new request is pending for the next round.
  - A 0x0066 fetch while not in ASSERT has no effect.
- Reset mid-operation: all state is cleared asynchronously, n_nmi releases immediately, and pending requests are lost.
- Counter widths: timeout counter $clog2(NMI_TIMEOUT+1); holdoff counter $clog2(HOLDOFF_FRAMES+1), minimum 1 bit. Neither counter wraps: both saturate at terminal count.

Optional Feature:
- Macro: NMI_ARB_TIMEOUT_EN.
- Defined: ASSERT counts clk28 cycles from entry. On reaching NMI_TIMEOUT without the 0x0066 fetch:
  - n_nmi<=1, pending[owner] cleared, timeout pulsed for 1 cycle;
  - go to HOLDOFF with no grant issued and no done expected.
- Undefined: no counter is present and the timeout output is tied to 0. ASSERT waits indefinitely (the CPU will eventually accept the NMI).

Decomposition:
- Shared package common: typedef enum nmiarb_state_t {NMIARB_IDLE, NMIARB_SYNC, NMIARB_ASSERT, NMIARB_SERVICE, NMIARB_HOLDOFF}, and localparam NMI_VECTOR = 16'h0066.
- One natural sub-module, rr_pick: combinational round-robin selector taking pending and rr_ptr, producing hit and index. Reusable for other shared-resource arbiters.

Test Plan:
- Single request, NREQ=2, HOLDOFF_FRAMES=2: req[0] rises mid-frame.
  - n_nmi falls on the clock of the next int_edge.
  - Fetch at 0x0066 -> n_nmi=1 and grant=2'b01 next clock.
  - done[0] -> grant=0, busy=0 after 2 further int_edges.
- Round-robin: req[0] and req[1] rise on the same clock with rr_ptr=1.
  - Owner order is 0 then 1.
  - Repeat with rr_ptr=0 -> order is 1 then 0.
- Non-preemption: req[1] rises while owner 0 is in SERVICE.
  - grant stays 2'b01 and n_nmi stays 1.
  - After done[0] and holdoff, req[1] is served next.
- Foreign done: done[1] is pulsed while owner is 0 -> no state change. Also, a stray fetch at 0x0066 in IDLE -> n_nmi stays 1.
- Timeout (NMI_ARB_TIMEOUT_EN, NMI_TIMEOUT=100): no 0x0066 fetch is issued.
  - At cycle 100 in ASSERT: n_nmi=1, timeout pulses once, grant stays 0, pending[owner] is cleared.
- Reset mid-ASSERT: rst asserted -> n_nmi=1 and busy=0 immediately (asynchronously); no grant appears after rst deasserts.
